// File: rtl/eth_tx_frame_ctrl.sv
// rtl/eth_tx_frame_ctrl.sv - Ethernet transmit frame sequencer: preamble/SFD, payload, pad, FCS, IFG
module eth_tx_frame_ctrl #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_LEN      = 60,
    parameter int IFG_CYCLES   = 12,
    parameter int CRC_TIMEOUT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        tx_err,
    output logic        crc_init,
    output logic        crc_calc,
    output logic        crc_finish,
    output logic        crc_data_valid,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_out,
    input  logic        crc_valid,
    output logic [15:0] frame_cnt,
    output logic [15:0] abort_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_PAY, ST_PAD, ST_FIN, ST_WAIT, ST_FCS, ST_IFG
    } state_t;

    localparam logic [15:0] L_PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] L_MIN_LEN   = 16'(MIN_LEN);
    localparam logic [15:0] L_TMO_LAST  = 16'(CRC_TIMEOUT - 1);
    // The IDLE cycle that samples the next s_valid is part of the gap after a frame;
    // after an abort the tx_err cycle itself is the first IFG cycle.
    localparam logic [15:0] L_IFG_FRAME = 16'(IFG_CYCLES - 2);
    localparam logic [15:0] L_IFG_ABORT = 16'(IFG_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0] r_fcs, w_fcs_nxt;
    logic [15:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [15:0] r_abort_cnt, w_abort_cnt_nxt;
    logic [7:0]  r_m_data, w_m_data_nxt;
    logic        r_m_valid, w_m_valid_nxt;
    logic        r_m_last, w_m_last_nxt;
    logic        r_tx_err, w_tx_err_nxt;
    logic        r_crc_init, w_crc_init_nxt;
    logic        r_crc_calc, w_crc_calc_nxt;
    logic        r_crc_finish, w_crc_finish_nxt;
    logic        r_crc_dv, w_crc_dv_nxt;
    logic [7:0]  r_crc_data, w_crc_data_nxt;
    logic [15:0] w_byte_inc;
    logic [7:0]  w_fcs_byte;
    logic        w_abort;
    logic        w_in_pay;
    logic        w_fcs_now;

    assign w_byte_inc = (r_byte_cnt < L_MIN_LEN) ? r_byte_cnt + 16'd1 : r_byte_cnt;

    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_cnt[1:0])
            2'd1:    w_fcs_byte = r_fcs[15:8];
            2'd2:    w_fcs_byte = r_fcs[7:0];
            default: w_fcs_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd0;
            r_byte_cnt   <= 16'd0;
            r_fcs        <= 32'd0;
            r_frame_cnt  <= 16'd0;
            r_abort_cnt  <= 16'd0;
            r_m_data     <= 8'h00;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_tx_err     <= 1'b0;
            r_crc_init   <= 1'b0;
            r_crc_calc   <= 1'b0;
            r_crc_finish <= 1'b0;
            r_crc_dv     <= 1'b0;
            r_crc_data   <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_fcs        <= w_fcs_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_abort_cnt  <= w_abort_cnt_nxt;
            r_m_data     <= w_m_data_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_m_last     <= w_m_last_nxt;
            r_tx_err     <= w_tx_err_nxt;
            r_crc_init   <= w_crc_init_nxt;
            r_crc_calc   <= w_crc_calc_nxt;
            r_crc_finish <= w_crc_finish_nxt;
            r_crc_dv     <= w_crc_dv_nxt;
            r_crc_data   <= w_crc_data_nxt;
        end
    end

    // Next state plus the registered outputs for the cycle being entered.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_fcs_nxt        = r_fcs;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_abort_cnt_nxt  = r_abort_cnt;
        w_m_data_nxt     = 8'h00;
        w_m_valid_nxt    = 1'b0;
        w_m_last_nxt     = 1'b0;
        w_tx_err_nxt     = 1'b0;
        w_crc_init_nxt   = 1'b0;
        w_crc_calc_nxt   = 1'b0;
        w_crc_finish_nxt = 1'b0;
        w_crc_dv_nxt     = 1'b0;
        w_crc_data_nxt   = 8'h00;
        w_abort          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_state_nxt   = ST_PRE;
                    w_cnt_nxt     = 16'd0;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = 8'h55;
                end
            end
            ST_PRE: begin
                w_m_valid_nxt = 1'b1;
                if (r_cnt == L_PRE_LAST) begin
                    w_state_nxt    = ST_SFD;
                    w_m_data_nxt   = 8'hD5;
                    w_crc_init_nxt = 1'b1;
                end else begin
                    w_cnt_nxt    = r_cnt + 16'd1;
                    w_m_data_nxt = 8'h55;
                end
            end
            ST_SFD: begin
                w_state_nxt    = ST_PAY;
                w_byte_cnt_nxt = 16'd0;
                w_crc_calc_nxt = 1'b1;
            end
            ST_PAY: begin
                if (!s_valid) begin
                    w_abort = 1'b1;
                end else begin
                    w_byte_cnt_nxt = w_byte_inc;
                    if (!s_last) begin
                        w_crc_calc_nxt = 1'b1;
                    end else if (w_byte_inc < L_MIN_LEN) begin
                        w_state_nxt    = ST_PAD;
                        w_m_valid_nxt  = 1'b1;
                        w_crc_calc_nxt = 1'b1;
                        w_crc_dv_nxt   = 1'b1;
                    end else begin
                        w_state_nxt      = ST_FIN;
                        w_crc_finish_nxt = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                w_byte_cnt_nxt = w_byte_inc;
                if (w_byte_inc == L_MIN_LEN) begin
                    w_state_nxt      = ST_FIN;
                    w_crc_finish_nxt = 1'b1;
                end else begin
                    w_m_valid_nxt  = 1'b1;
                    w_crc_calc_nxt = 1'b1;
                    w_crc_dv_nxt   = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = 16'd0;
            end
            ST_WAIT: begin
                if (crc_valid) begin
                    w_fcs_nxt     = crc_out;
                    w_state_nxt   = ST_FCS;
                    w_cnt_nxt     = 16'd1;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = crc_out[23:16];
                end else if (r_cnt == L_TMO_LAST) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_FCS: begin
                if (r_cnt == 16'd3) begin
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    w_state_nxt     = ST_IFG;
                    w_cnt_nxt       = L_IFG_FRAME;
                end else begin
                    w_cnt_nxt     = r_cnt + 16'd1;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = w_fcs_byte;
                    w_m_last_nxt  = (r_cnt == 16'd2);
                end
            end
            ST_IFG: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_nxt     = ST_IFG;
            w_cnt_nxt       = L_IFG_ABORT;
            w_tx_err_nxt    = 1'b1;
            w_abort_cnt_nxt = r_abort_cnt + 16'd1;
        end
    end

    // Payload passes straight through in PAY; FCS byte 0 leaves in the same cycle crc_valid arrives.
    assign w_in_pay  = (r_state == ST_PAY);
    assign w_fcs_now = (r_state == ST_WAIT) && crc_valid;

    assign s_ready        = w_in_pay;
    assign m_valid        = w_in_pay ? s_valid : (w_fcs_now | r_m_valid);
    assign m_data         = w_in_pay ? s_data : (w_fcs_now ? crc_out[31:24] : r_m_data);
    assign crc_data_valid = w_in_pay ? s_valid : r_crc_dv;
    assign crc_data       = w_in_pay ? s_data : r_crc_data;
    assign m_last         = r_m_last;
    assign tx_err         = r_tx_err;
    assign crc_init       = r_crc_init;
    assign crc_calc       = r_crc_calc;
    assign crc_finish     = r_crc_finish;
    assign frame_cnt      = r_frame_cnt;
    assign abort_cnt      = r_abort_cnt;

endmodule
